// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared helpers and elaboration checks for sync_fifo_param.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int c_MIN_DEPTH = 4;

    // Occupancy needs one bit more than the address to represent DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value >= 1) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit depth_ok(input int depth);
        return is_pow2(depth) && (depth >= c_MIN_DEPTH);
    endfunction

    function automatic bit thresholds_ok(input int depth, input int afull_th,
                                         input int aempty_th);
        return (afull_th >= 1) && (afull_th <= depth - 1) &&
               (aempty_th >= 0) && (aempty_th <= depth - 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ram
// Description : Simple dual-port RAM, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wren,
    input  logic [ADDR_W-1:0] i_wraddr,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic [ADDR_W-1:0] i_rdaddr,
    output logic [DATA_W-1:0] o_rddata
);

    // Contents are intentionally never reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wren) begin
            r_mem[i_wraddr] <= i_wrdata;
        end
    end

    assign o_rddata = r_mem[i_rdaddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with count, threshold flags,
//               sticky errors and optional first-word-fall-through read.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int DEPTH     = 1024,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    input  logic              i_err_clr,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_rdvalid,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    output logic              o_ovf,
    output logic              o_unf
);

    localparam int              c_CNT_W     = count_width(DEPTH);
    localparam logic [ADDR_W:0] c_DEPTH     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_AFULL_TH  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] c_AEMPTY_TH = (ADDR_W + 1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] c_CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
    end
    if (!thresholds_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_thresholds
        $error("sync_fifo_param: AFULL_TH or AEMPTY_TH out of range");
    end
    if ((ADDR_W + 1) != c_CNT_W) begin : g_bad_addr_w
        $error("sync_fifo_param: ADDR_W must equal $clog2(DEPTH)");
    end

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_unf;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_ram_rdata;

    // Flags come from the count register alone, so they lag an access by one cycle.
    assign w_full      = (r_count == c_DEPTH);
    assign w_empty     = (r_count == '0);
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_alm_full  = (r_count >= c_AFULL_TH);
    assign o_alm_empty = (r_count <= c_AEMPTY_TH);
    assign o_count     = r_count;
    assign o_ovf       = r_ovf;
    assign o_unf       = r_unf;

    assign w_wr_acc = i_wren && !w_full;
    assign w_rd_acc = i_rden && !w_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (i_wren && w_full) begin
                r_ovf <= 1'b1;
            end else if (i_err_clr) begin
                r_ovf <= 1'b0;
            end
            if (i_rden && w_empty) begin
                r_unf <= 1'b1;
            end else if (i_err_clr) begin
                r_unf <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .i_wren   (w_wr_acc),
        .i_wraddr (r_wr_ptr),
        .i_wrdata (i_wrdata),
        .i_rdaddr (r_rd_ptr),
        .o_rddata (w_ram_rdata)
    );

    if (FWFT == 0) begin : g_std_read
        logic [DATA_W-1:0] r_rddata;
        logic              r_rdvalid;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_rddata  <= '0;
                r_rdvalid <= 1'b0;
            end else if (w_rd_acc) begin
                r_rddata  <= w_ram_rdata;
                r_rdvalid <= 1'b1;
            end else begin
                r_rdvalid <= 1'b0;
            end
        end

        assign o_rddata  = r_rddata;
        assign o_rdvalid = r_rdvalid;
    end else begin : g_fwft_read
        // Head of queue is always presented; i_rden only pops it.
        assign o_rddata  = w_ram_rdata;
        assign o_rdvalid = !w_empty;
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Directed self-checking bench, standard and FWFT instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rstn;
    logic       wren, rden, err_clr;
    logic [7:0] wrdata;
    logic [7:0] s_rddata;
    logic       s_rdvalid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
    logic [3:0] s_count;

    logic       f_wren, f_rden, f_err_clr;
    logic [7:0] f_wrdata;
    logic [7:0] f_rddata;
    logic       f_rdvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
    logic [3:0] f_count;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)) u_std (
        .clk(clk), .rstn(rstn), .i_wren(wren), .i_wrdata(wrdata), .i_rden(rden),
        .i_err_clr(err_clr), .o_rddata(s_rddata), .o_rdvalid(s_rdvalid), .o_count(s_count),
        .o_full(s_full), .o_empty(s_empty), .o_alm_full(s_afull), .o_alm_empty(s_aempty),
        .o_ovf(s_ovf), .o_unf(s_unf)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
        .clk(clk), .rstn(rstn), .i_wren(f_wren), .i_wrdata(f_wrdata), .i_rden(f_rden),
        .i_err_clr(f_err_clr), .o_rddata(f_rddata), .o_rdvalid(f_rdvalid), .o_count(f_count),
        .o_full(f_full), .o_empty(f_empty), .o_alm_full(f_afull), .o_alm_empty(f_aempty),
        .o_ovf(f_ovf), .o_unf(f_unf)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wren = 1'b1; wrdata = d;
        step();
        wren = 1'b0;
    endtask

    task automatic drain_quiet(input int n);
        rden = 1'b1;
        repeat (n) step();
        rden = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        step(); step();
        rstn = 1'b1;
        checks++; if (s_count !== 4'd0) $display("FAIL reset_count got %0d exp 0", s_count); else passed++;
        checks++; if ({s_empty, s_aempty, s_full, s_afull} !== 4'b1100)
            $display("FAIL reset_flags got %b exp 1100", {s_empty, s_aempty, s_full, s_afull}); else passed++;
        checks++; if ({s_ovf, s_unf, s_rdvalid} !== 3'b000)
            $display("FAIL reset_err_valid got %b exp 000", {s_ovf, s_unf, s_rdvalid}); else passed++;
        checks++; if (s_rddata !== 8'h00) $display("FAIL reset_rddata got %h exp 00", s_rddata); else passed++;
    endtask

    task automatic test_fill_drain;
        for (int k = 1; k <= 8; k++) push(8'(k));
        checks++; if (s_full !== 1'b1) $display("FAIL fill_full got %b exp 1", s_full); else passed++;
        checks++; if (s_count !== 4'd8) $display("FAIL fill_count got %0d exp 8", s_count); else passed++;
        rden = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (s_rdvalid !== 1'b1 || s_rddata !== 8'(i + 1))
                $display("FAIL drain_data[%0d] got v=%b %h exp v=1 %h", i, s_rdvalid, s_rddata, 8'(i + 1));
            else passed++;
        end
        rden = 1'b0;
        step();
        checks++; if (s_empty !== 1'b1 || s_rdvalid !== 1'b0)
            $display("FAIL drain_empty got e=%b v=%b exp e=1 v=0", s_empty, s_rdvalid); else passed++;
        checks++; if (s_rddata !== 8'h08) $display("FAIL drain_hold got %h exp 08", s_rddata); else passed++;
    endtask

    task automatic test_thresholds;
        for (int k = 1; k <= 6; k++) begin
            push(8'(8'h40 + k));
            checks++; if (s_afull !== (k >= 6))
                $display("FAIL alm_full_at_%0d got %b exp %b", k, s_afull, (k >= 6)); else passed++;
        end
        rden = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            step();
            checks++; if (s_aempty !== ((6 - j) <= 2))
                $display("FAIL alm_empty_at_%0d got %b exp %b", 6 - j, s_aempty, ((6 - j) <= 2)); else passed++;
        end
        rden = 1'b0;
        drain_quiet(2);
    endtask

    task automatic test_errors;
        for (int k = 0; k < 8; k++) push(8'(8'h11 + k));
        push(8'hAA);
        checks++; if (s_ovf !== 1'b1) $display("FAIL ovf_set got %b exp 1", s_ovf); else passed++;
        checks++; if (s_count !== 4'd8) $display("FAIL ovf_count got %0d exp 8", s_count); else passed++;
        rden = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            if (i < 8) begin
                checks++; if (s_rddata !== 8'(8'h11 + i))
                    $display("FAIL ovf_order[%0d] got %h exp %h", i, s_rddata, 8'(8'h11 + i)); else passed++;
            end
        end
        rden = 1'b0;
        checks++; if (s_unf !== 1'b1 || s_rdvalid !== 1'b0)
            $display("FAIL unf_set got u=%b v=%b exp u=1 v=0", s_unf, s_rdvalid); else passed++;
        checks++; if (s_rddata !== 8'h18) $display("FAIL no_aa_read got %h exp 18", s_rddata); else passed++;
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++; if ({s_ovf, s_unf} !== 2'b00) $display("FAIL err_clr got %b exp 00", {s_ovf, s_unf}); else passed++;
        for (int k = 0; k < 8; k++) push(8'h70);
        wren = 1'b1; wrdata = 8'hCC; err_clr = 1'b1;
        step();
        wren = 1'b0; err_clr = 1'b0;
        checks++; if (s_ovf !== 1'b1) $display("FAIL set_beats_clr got %b exp 1", s_ovf); else passed++;
        err_clr = 1'b1; step(); err_clr = 1'b0;
        drain_quiet(8);
    endtask

    task automatic test_simultaneous;
        for (int k = 0; k < 8; k++) push(8'(8'h21 + k));
        rden = 1'b1; wren = 1'b1; wrdata = 8'hBB;
        step();
        wren = 1'b0;
        // Read accepted, write rejected while full: occupancy drops by one.
        checks++; if (s_count !== 4'd7 || s_ovf !== 1'b1)
            $display("FAIL full_rdwr got cnt=%0d ovf=%b exp cnt=7 ovf=1", s_count, s_ovf); else passed++;
        checks++; if (s_rddata !== 8'h21) $display("FAIL full_rdwr_data got %h exp 21", s_rddata); else passed++;
        for (int i = 0; i < 7; i++) begin
            step();
            checks++; if (s_rddata !== 8'(8'h22 + i))
                $display("FAIL full_rdwr_rest[%0d] got %h exp %h", i, s_rddata, 8'(8'h22 + i)); else passed++;
        end
        rden = 1'b0;
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++; if (s_empty !== 1'b1) $display("FAIL bb_dropped got empty=%b exp 1", s_empty); else passed++;

        for (int k = 0; k < 4; k++) push(8'(8'h31 + k));
        rden = 1'b1; wren = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wrdata = 8'(8'h35 + i);
            step();
            checks++; if (s_count !== 4'd4 || s_rddata !== 8'(8'h31 + i))
                $display("FAIL wrap[%0d] got cnt=%0d %h exp cnt=4 %h", i, s_count, s_rddata, 8'(8'h31 + i));
            else passed++;
        end
        wren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (s_rddata !== 8'(8'h45 + i))
                $display("FAIL wrap_tail[%0d] got %h exp %h", i, s_rddata, 8'(8'h45 + i)); else passed++;
        end
        rden = 1'b0;
        step();
        checks++; if (s_empty !== 1'b1) $display("FAIL wrap_empty got %b exp 1", s_empty); else passed++;
    endtask

    task automatic test_reset_midstream;
        for (int k = 0; k < 5; k++) push(8'(8'h61 + k));
        rden = 1'b1; step(); rden = 1'b0;
        rstn = 1'b0; step(); rstn = 1'b1;
        checks++; if (s_count !== 4'd0 || s_empty !== 1'b1 || s_rdvalid !== 1'b0)
            $display("FAIL mid_reset got cnt=%0d e=%b v=%b exp 0 1 0", s_count, s_empty, s_rdvalid); else passed++;
        push(8'h77);
        rden = 1'b1; step(); rden = 1'b0;
        checks++; if (s_rddata !== 8'h77 || s_rdvalid !== 1'b1)
            $display("FAIL post_reset_data got v=%b %h exp v=1 77", s_rdvalid, s_rddata); else passed++;
        checks++; if (s_empty !== 1'b1) $display("FAIL post_reset_empty got %b exp 1", s_empty); else passed++;
    endtask

    task automatic test_fwft;
        checks++; if (f_rdvalid !== 1'b0 || f_empty !== 1'b1)
            $display("FAIL fwft_idle got v=%b e=%b exp 0 1", f_rdvalid, f_empty); else passed++;
        f_wren = 1'b1; f_wrdata = 8'h5A; step(); f_wren = 1'b0;
        checks++; if (f_rdvalid !== 1'b1 || f_rddata !== 8'h5A)
            $display("FAIL fwft_show got v=%b %h exp v=1 5a", f_rdvalid, f_rddata); else passed++;
        f_rden = 1'b1; step(); f_rden = 1'b0;
        checks++; if (f_empty !== 1'b1 || f_rdvalid !== 1'b0)
            $display("FAIL fwft_pop got e=%b v=%b exp 1 0", f_empty, f_rdvalid); else passed++;
        f_rden = 1'b1; f_wren = 1'b1; f_wrdata = 8'h3C; step();
        f_rden = 1'b0; f_wren = 1'b0;
        checks++; if (f_count !== 4'd1 || f_unf !== 1'b1 || f_rddata !== 8'h3C)
            $display("FAIL fwft_rd_empty got cnt=%0d unf=%b %h exp 1 1 3c", f_count, f_unf, f_rddata); else passed++;
    endtask

    initial begin
        rstn = 1'b0; wren = 1'b0; rden = 1'b0; err_clr = 1'b0; wrdata = '0;
        f_wren = 1'b0; f_rden = 1'b0; f_err_clr = 1'b0; f_wrdata = '0;
        test_reset();
        test_fill_drain();
        test_thresholds();
        test_errors();
        test_simultaneous();
        test_reset_midstream();
        test_fwft();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
